// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: forward-select
// codes and the per-stage destination records tracked in EX, MEM and WB.
package hazard_pkg;

   // Record register fields are this wide; the controller's AW must not exceed it.
   localparam int unsigned REC_AW = 8;

   typedef logic [1:0] fwd_sel_t;

   localparam fwd_sel_t FWD_RF  = 2'b00;
   localparam fwd_sel_t FWD_MEM = 2'b10;
   localparam fwd_sel_t FWD_WB  = 2'b01;

   typedef struct packed {
      logic              v;
      logic              rw;
      logic              mr;
      logic [REC_AW-1:0] rd;
   } stage_rec_t;

   typedef struct packed {
      logic              v;
      logic              rw;
      logic [REC_AW-1:0] rd;
   } wb_rec_t;

endpackage

// File: rtl/hazard_fwd_match.sv
// Forward-select for one EX source operand: MEM/WB destination compare with
// MEM taking priority and register 0 never forwarded.
module hazard_fwd_match
   import hazard_pkg::*;
#(
   parameter int unsigned AW = 5
) (
   input  logic [AW-1:0] rs_i,
   input  logic          used_i,
   input  stage_rec_t    mem_i,
   input  wb_rec_t       wb_i,
   output fwd_sel_t      sel_o,
   output logic          err_o
);

   logic [REC_AW-1:0] rs_ext;
   logic              mem_hit;
   logic              wb_hit;

   assign rs_ext  = REC_AW'(rs_i);
   assign mem_hit = used_i & mem_i.v & mem_i.rw & (mem_i.rd != '0) & (mem_i.rd == rs_ext);
   assign wb_hit  = used_i & wb_i.v & wb_i.rw & (wb_i.rd != '0) & (wb_i.rd == rs_ext);

   always_comb begin
      sel_o = FWD_RF;
      if (mem_hit) begin
         sel_o = FWD_MEM;
      end else if (wb_hit) begin
         sel_o = FWD_WB;
      end
   end

   // A load still in MEM cannot supply data yet; the load-use stall should prevent this.
   assign err_o = mem_hit & mem_i.mr;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: tracks EX/MEM/WB
// destinations, forwards EX operands, stalls on load-use and counts stalls.
module hazard_forward_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned AW      = 5,
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  id_valid,
   input  logic [NUM_SRC*AW-1:0] id_rs,
   input  logic [NUM_SRC-1:0]    id_rs_used,
   input  logic [AW-1:0]         id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  flush,
   input  logic                  mem_stall,
   output logic [NUM_SRC*2-1:0]  fwd_sel,
   output logic                  stall_id,
   output logic                  bubble_ex,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic                  fwd_err
);

   stage_rec_t            ex_q, ex_d;
   stage_rec_t            mem_q, mem_d;
   wb_rec_t               wb_q, wb_d;
   logic [NUM_SRC*AW-1:0] ex_rs_q, ex_rs_d;
   logic [NUM_SRC-1:0]    ex_used_q, ex_used_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  err_q, err_d;

   logic [NUM_SRC-1:0]    src_hit;
   logic [NUM_SRC-1:0]    op_err;
   logic                  ld_use;
   logic                  stall_raw;
   logic                  bubble_raw;

   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
         assign src_hit[gi] = id_rs_used[gi] & (REC_AW'(id_rs[gi*AW +: AW]) == ex_q.rd);

         hazard_fwd_match #(
            .AW (AW)
         ) u_match (
            .rs_i   (ex_rs_q[gi*AW +: AW]),
            .used_i (ex_used_q[gi] & ex_q.v),
            .mem_i  (mem_q),
            .wb_i   (wb_q),
            .sel_o  (fwd_sel[gi*2 +: 2]),
            .err_o  (op_err[gi])
         );
      end
   endgenerate

   // Flush kills the ID instruction first, so a flushed consumer never stalls.
   assign ld_use     = id_valid & ~flush & ex_q.v & ex_q.mr & (ex_q.rd != '0) & (|src_hit);
   assign stall_raw  = ld_use | mem_stall;
   assign bubble_raw = (ld_use | flush | ~id_valid) & ~mem_stall;

   // While reset is sampled the pipe is being emptied, so nothing is held back.
   assign stall_id  = reset_n & stall_raw;
   assign bubble_ex = reset_n & bubble_raw;
   assign stall_cnt = cnt_q;
   assign fwd_err   = err_q;

   always_comb begin
      ex_d      = ex_q;
      mem_d     = mem_q;
      wb_d      = wb_q;
      ex_rs_d   = ex_rs_q;
      ex_used_d = ex_used_q;
      if (!mem_stall) begin
         wb_d.v  = mem_q.v;
         wb_d.rw = mem_q.rw;
         wb_d.rd = mem_q.rd;
         mem_d   = ex_q;
         if (bubble_raw) begin
            ex_d      = '0;
            ex_rs_d   = '0;
            ex_used_d = '0;
         end else begin
            ex_d.v    = 1'b1;
            ex_d.rw   = id_reg_write;
            ex_d.mr   = id_mem_read;
            ex_d.rd   = REC_AW'(id_rd);
            ex_rs_d   = id_rs;
            ex_used_d = id_rs_used;
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stall_raw && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      err_d = err_q | (|op_err);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ex_q      <= '0;
         mem_q     <= '0;
         wb_q      <= '0;
         ex_rs_q   <= '0;
         ex_used_q <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         ex_q      <= ex_d;
         mem_q     <= mem_d;
         wb_q      <= wb_d;
         ex_rs_q   <= ex_rs_d;
         ex_used_q <= ex_used_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: directed pipeline scenarios then random
// traffic, all checked against an instruction-level pipeline model.
module tb_hazard_forward_ctrl;

   localparam int AW   = 5;
   localparam int NS   = 2;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset_n;
   logic             id_valid;
   logic [NS*AW-1:0] id_rs;
   logic [NS-1:0]    id_rs_used;
   logic [AW-1:0]    id_rd;
   logic             id_reg_write;
   logic             id_mem_read;
   logic             flush;
   logic             mem_stall;
   logic [NS*2-1:0]  fwd_sel;
   logic             stall_id;
   logic             bubble_ex;
   logic [CW-1:0]    stall_cnt;
   logic             fwd_err;

   hazard_forward_ctrl #(
      .AW      (AW),
      .NUM_SRC (NS),
      .CNT_W   (CW)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rs_used   (id_rs_used),
      .id_rd        (id_rd),
      .id_reg_write (id_reg_write),
      .id_mem_read  (id_mem_read),
      .flush        (flush),
      .mem_stall    (mem_stall),
      .fwd_sel      (fwd_sel),
      .stall_id     (stall_id),
      .bubble_ex    (bubble_ex),
      .stall_cnt    (stall_cnt),
      .fwd_err      (fwd_err)
   );

   // Model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB, each an instruction record.
   typedef struct packed {
      bit               v;
      bit               rw;
      bit               mr;
      logic [AW-1:0]    rd;
      logic [NS*AW-1:0] rs;
      logic [NS-1:0]    used;
   } ins_t;

   ins_t pipe [3];
   int   m_cnt = 0;
   bit   m_err = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   step_no = 0;
   logic last_stall;
   logic last_bubble;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Newest producer (MEM before WB) of the EX operand's register, never x0.
   function automatic logic [1:0] m_fwd(input int i);
      logic [AW-1:0] r;
      if (!pipe[0].v || !pipe[0].used[i]) return 2'b00;
      r = pipe[0].rs[i*AW +: AW];
      for (int s = 1; s <= 2; s++) begin
         if (pipe[s].v && pipe[s].rw && pipe[s].rd != 0 && pipe[s].rd == r)
            return (s == 1) ? 2'b10 : 2'b01;
      end
      return 2'b00;
   endfunction

   task automatic step(input bit rst_n, input bit v, input int rd, input bit rw, input bit mr,
                       input int rs0, input int rs1, input bit [1:0] used,
                       input bit fl, input bit ms, input bit do_chk);
      ins_t            nw;
      bit              ldu;
      bit              e_stall;
      bit              e_bub;
      logic [NS*2-1:0] e_fwd;
      @(negedge clk);
      reset_n      = rst_n;
      id_valid     = v;
      id_rd        = AW'(rd);
      id_reg_write = rw;
      id_mem_read  = mr;
      id_rs        = {AW'(rs1), AW'(rs0)};
      id_rs_used   = used;
      flush        = fl;
      mem_stall    = ms;
      #1;
      ldu = 1'b0;
      for (int i = 0; i < NS; i++)
         if (used[i] && id_rs[i*AW +: AW] == pipe[0].rd) ldu = 1'b1;
      ldu     = ldu && rst_n && v && !fl && pipe[0].v && pipe[0].mr && pipe[0].rd != 0;
      e_stall = rst_n && (ldu || ms);
      e_bub   = rst_n && (ldu || fl || !v) && !ms;
      for (int i = 0; i < NS; i++) e_fwd[i*2 +: 2] = m_fwd(i);
      last_stall  = stall_id;
      last_bubble = bubble_ex;
      if (do_chk) begin
         check("fwd_sel", 32'(fwd_sel), 32'(e_fwd));
         check("stall_id", 32'(stall_id), 32'(e_stall));
         check("bubble_ex", 32'(bubble_ex), 32'(e_bub));
         check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
         check("fwd_err", 32'(fwd_err), 32'(m_err));
      end
      $display("step %0d rst_n=%0b v=%0b rd=%0d rw=%0b mr=%0b rs=%0d,%0d used=%b fl=%0b ms=%0b | fwd=%b stall=%b bub=%b cnt=%0d err=%b",
               step_no, rst_n, v, rd, rw, mr, rs0, rs1, used, fl, ms, fwd_sel, stall_id, bubble_ex, stall_cnt, fwd_err);
      step_no++;
      nw.v    = 1'b1;
      nw.rw   = rw;
      nw.mr   = mr;
      nw.rd   = AW'(rd);
      nw.rs   = {AW'(rs1), AW'(rs0)};
      nw.used = used;
      @(posedge clk);
      if (!rst_n) begin
         for (int s = 0; s < 3; s++) pipe[s] = '0;
         m_cnt = 0;
         m_err = 1'b0;
      end else begin
         for (int i = 0; i < NS; i++)
            if (e_fwd[i*2 +: 2] == 2'b10 && pipe[1].mr) m_err = 1'b1;
         if (e_stall) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
         if (!ms) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = e_bub ? ins_t'('0) : nw;
         end
      end
   endtask

   task automatic nop();
      step(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
   endtask

   initial begin
      for (int s = 0; s < 3; s++) pipe[s] = '0;

      // Reset held three cycles under random inputs
      for (int k = 0; k < 3; k++)
         step(0, 1'($urandom), $urandom_range(0, 31), 1'($urandom), 1'($urandom),
              $urandom_range(0, 31), $urandom_range(0, 31), 2'($urandom),
              1'($urandom), 1'($urandom), k != 0);
      check("rst_stall_id", 32'(last_stall), 32'd0);

      // ALU chain on x5
      step(1, 1, 5, 1, 0, 0, 0, 2'b00, 0, 0, 1);
      step(1, 1, 6, 1, 0, 5, 2, 2'b11, 0, 0, 1);
      #1 check("alu_fwd_mem", 32'(fwd_sel[1:0]), 32'(2'b10));
      step(1, 1, 9, 1, 0, 5, 0, 2'b01, 0, 0, 1);
      #1 check("alu_fwd_wb", 32'(fwd_sel[1:0]), 32'(2'b01));

      // Load-use: lw x7; add x8,x7,x1
      step(1, 1, 7, 1, 1, 0, 0, 2'b00, 0, 0, 1);
      step(1, 1, 8, 1, 0, 7, 1, 2'b11, 0, 0, 1);
      check("lu_stall", 32'(last_stall), 32'd1);
      check("lu_bubble", 32'(last_bubble), 32'd1);
      step(1, 1, 8, 1, 0, 7, 1, 2'b11, 0, 0, 1);
      check("lu_release", 32'(last_stall), 32'd0);
      #1 check("lu_fwd_wb", 32'(fwd_sel[1:0]), 32'(2'b01));
      check("lu_cnt", 32'(stall_cnt), 32'd1);

      // x0 never forwarded; MEM beats WB
      step(1, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0, 1);
      step(1, 1, 11, 1, 0, 0, 0, 2'b01, 0, 0, 1);
      #1 check("x0_fwd", 32'(fwd_sel[1:0]), 32'(2'b00));
      step(1, 1, 3, 1, 0, 0, 0, 2'b00, 0, 0, 1);
      step(1, 1, 3, 1, 0, 0, 0, 2'b00, 0, 0, 1);
      step(1, 1, 12, 1, 0, 3, 0, 2'b01, 0, 0, 1);
      #1 check("prio_fwd", 32'(fwd_sel[1:0]), 32'(2'b10));

      // Flush of a load consumer
      nop();
      nop();
      step(1, 1, 4, 1, 1, 0, 0, 2'b00, 0, 0, 1);
      step(1, 1, 9, 1, 0, 4, 0, 2'b01, 1, 0, 1);
      check("fl_stall", 32'(last_stall), 32'd0);
      check("fl_bubble", 32'(last_bubble), 32'd1);
      #1 check("fl_cnt", 32'(stall_cnt), 32'd1);

      // Memory freeze mid-chain
      step(1, 1, 10, 1, 0, 0, 0, 2'b00, 0, 0, 1);
      step(1, 1, 13, 1, 0, 10, 0, 2'b01, 0, 0, 1);
      for (int k = 0; k < 4; k++) begin
         step(1, 1, 14, 1, 0, 10, 0, 2'b01, 0, 1, 1);
         #1 check("ms_fwd_hold", 32'(fwd_sel[1:0]), 32'(2'b10));
      end
      check("ms_cnt", 32'(stall_cnt), 32'd5);
      for (int k = 0; k < 14; k++) step(1, 1, 14, 1, 0, 10, 0, 2'b01, 0, 1, 1);
      #1 check("cnt_sat", 32'(stall_cnt), 32'(CMAX));
      step(1, 1, 14, 1, 0, 10, 0, 2'b01, 0, 0, 1);

      // Reset sampled while a load-use is pending
      step(1, 1, 7, 1, 1, 0, 0, 2'b00, 0, 0, 1);
      step(0, 1, 8, 1, 0, 7, 0, 2'b01, 0, 0, 1);
      check("rst_mid_stall", 32'(last_stall), 32'd0);
      #1 check("rst_cnt", 32'(stall_cnt), 32'd0);

      // Random traffic on a small register window to provoke hazards
      for (int k = 0; k < 300; k++)
         step(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) != 0),
              $urandom_range(0, 7), 1'($urandom), ($urandom_range(0, 2) == 0),
              $urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), 1);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
